move_unit: RTL and testbench
============================

Name: move_unit

Overview:
- Next-generation move/coprocessor-transfer unit for the memory-access stage.
- Executes MOVZ, MOVN, MFHI, MFLO, MTHI, MTLO, MFC0 and MTC0.
- Owns the architectural HI/LO registers.
- Talks to CP0 over a request/acknowledge port with a bounded timeout.
- Accepts one instruction at a time through a valid/ready handshake and returns a registered result plus a GPR write-enable.

Parameters:
- DATA_WIDTH, 32, width of GPR/HI/LO/CP0 data.
- CP0_ADDR_WIDTH, 5, CP0 register number width (raw_inst[15:11]).
- CP0_SEL_WIDTH, 3, CP0 select field width (raw_inst[2:0]).
- CP0_TIMEOUT, 15, max cycles waiting for cp0_ack before abort; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush; aborts any operation
- in_valid  in  1  instruction present
- in_ready  out  1  unit can accept
- inst  in  `INST_BUS  decoded instruction code
- raw_inst  in  `DATA_BUS  raw instruction word
- data  in  DATA_WIDTH  rs value (MOV*/MT*) or rt value (MTC0)
- cond  in  DATA_WIDTH  rt value for MOVZ/MOVN test
- md_we  in  1  multiply/divide unit writes HI/LO
- md_hi, md_lo  in  DATA_WIDTH  multiply/divide results
- hi, lo  out  DATA_WIDTH  current HI/LO
- cp0_req  out  1  CP0 access request
- cp0_we  out  1  1 = write, 0 = read
- cp0_addr  out  CP0_ADDR_WIDTH  CP0 register
- cp0_sel  out  CP0_SEL_WIDTH  CP0 select
- cp0_wdata  out  DATA_WIDTH  write data
- cp0_rdata  in  DATA_WIDTH  read data, valid with cp0_ack
- cp0_ack  in  1  CP0 completes the access
- out_valid  out  1  one-cycle result strobe
- res  out  DATA_WIDTH  value for GPR
- res_we  out  1  GPR write enable, qualified by out_valid
- cp0_err  out  1  one-cycle timeout strobe

Behaviour:
- Reset (rst_n low at posedge): state IDLE; hi = lo = 0; all outputs 0 except in_ready = 1; timeout counter 0.
- Clock and reset are fixed as decided: single clock clk; rst_n is synchronous and active-low.
- FSM states:
  - IDLE: in_ready = 1. Accept on in_valid.
  - CP0: in_ready = 0. cp0_req held high with stable addr/sel/we/wdata until the cp0_ack cycle.
  - RESP: one cycle, out_valid = 1. Transitions to IDLE.
- Accept in IDLE:
  - Non-CP0 ops → RESP; result at the next edge (latency 1).
  - MFC0/MTC0 → CP0 with cp0_req asserted from the next cycle.
  - Unrecognised inst → RESP with res_we = 0.
- MOVZ: res = data, res_we = (cond == 0). MOVN: res = data, res_we = (cond != 0).
- MFHI/MFLO: res = HI/LO value as of the accept cycle, including an md_we write in that same cycle (bypass); res_we = 1.
- MTHI/MTLO: update HI/LO at the accept edge; res_we = 0.
  - A same-cycle md_we still writes the other register.
  - The MT* instruction wins for its target register.
- md_we in any state updates both HI and LO.
- MFC0: on cp0_ack, capture cp0_rdata → RESP, res = captured data, res_we = 1.
- MTC0: cp0_we = 1, cp0_wdata = data. On ack → RESP, res_we = 0.
- cp0_ack outside the CP0 state is ignored.
- Timeout: the counter increments each CP0 cycle without ack. On reaching CP0_TIMEOUT:
  - drop cp0_req;
  - pulse cp0_err together with out_valid;
  - res = 0, res_we = 0; return via RESP.
  - If ack arrives in the same cycle as the limit, ack wins and there is no error.
- flush has priority over everything except reset. Next state is IDLE, with cp0_req, out_valid, res_we and cp0_err = 0.
  - An instruction presented in the flush cycle is not accepted.
  - An MTHI/MTLO already accepted stays committed.
  - An MTC0 acked in the flush cycle is considered committed by CP0.
- Outputs are registered; res holds its last value when out_valid = 0.

Decomposition:
- Shared defines (existing defines header):
  - INST codes MOVZ, MOVN, MFHI, MFLO, MTHI, MTLO, MFC0, MTC0;
  - state encodings MV_IDLE, MV_CP0, MV_RESP;
  - MEM_READ/MEM_WRITE for cp0_we.
- One natural sub-module: hilo_reg, holding the HI/LO registers with md_we/MT* priority and same-cycle read bypass.

Test Plan:
- Reset mid-CP0 wait (cp0_req = 1) → next cycle cp0_req = 0, in_ready = 1, hi = lo = 0.
- MOVZ data=0x1234, cond=0 → one cycle later out_valid = 1, res = 0x1234, res_we = 1. Same with cond=5 → res_we = 0. MOVN with cond=5 → res_we = 1.
- MTHI data=0xAAAA0000 in the same cycle as md_we (md_hi=0x1, md_lo=0x2) → hi = 0xAAAA0000, lo = 0x2. Then MFLO → res = 0x2.
- MFC0 raw_inst[15:11]=12, sel=0, ack after 3 cycles with rdata=0x0040FF01 → cp0_req high 3 cycles, addr = 12, then res = 0x0040FF01, res_we = 1.
- MTC0 with no ack for CP0_TIMEOUT=15 cycles → cp0_err and out_valid pulse together, res_we = 0, cp0_req drops. Repeat with ack on cycle 15 → no error.
- flush during MTC0 wait → IDLE next cycle, no out_valid. MFHI presented with flush → not accepted, in_ready stays 1.

Source files
------------

// File: rtl/move_unit_pkg.sv
// Shared instruction codes, FSM state encoding and CP0 direction codes
// for the move/coprocessor-transfer unit.
package move_unit_pkg;

   localparam int INST_WIDTH = 8;

   localparam logic [INST_WIDTH-1:0] INST_MOVZ = 8'h01;
   localparam logic [INST_WIDTH-1:0] INST_MOVN = 8'h02;
   localparam logic [INST_WIDTH-1:0] INST_MFHI = 8'h03;
   localparam logic [INST_WIDTH-1:0] INST_MFLO = 8'h04;
   localparam logic [INST_WIDTH-1:0] INST_MTHI = 8'h05;
   localparam logic [INST_WIDTH-1:0] INST_MTLO = 8'h06;
   localparam logic [INST_WIDTH-1:0] INST_MFC0 = 8'h07;
   localparam logic [INST_WIDTH-1:0] INST_MTC0 = 8'h08;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   typedef enum logic [1:0] {
      MV_IDLE = 2'd0,
      MV_CP0  = 2'd1,
      MV_RESP = 2'd2
   } mv_state_e;

   function automatic logic is_cp0(input logic [INST_WIDTH-1:0] op);
      return (op == INST_MFC0) || (op == INST_MTC0);
   endfunction

endpackage

// File: rtl/move_unit_hilo.sv
// Architectural HI/LO registers. The multiply/divide unit writes both
// halves; an MTHI/MTLO in the same cycle overrides only its own half.
// The bypass outputs show the value a same-cycle MFHI/MFLO must return.
module hilo_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         md_we_i,
   input  logic [W-1:0] md_hi_i,
   input  logic [W-1:0] md_lo_i,
   input  logic         mthi_we_i,
   input  logic         mtlo_we_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o,
   output logic [W-1:0] hi_byp_o,
   output logic [W-1:0] lo_byp_o
);

   logic [W-1:0] hi_q, hi_d, lo_q, lo_d;

   // Bypass the md result for reads, then let MT* win for its own half
   always_comb begin
      hi_byp_o = md_we_i ? md_hi_i : hi_q;
      lo_byp_o = md_we_i ? md_lo_i : lo_q;
      hi_d     = mthi_we_i ? wdata_i : hi_byp_o;
      lo_d     = mtlo_we_i ? wdata_i : lo_byp_o;
   end

   // HI/LO storage with synchronous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/move_unit.sv
// Move / coprocessor-transfer unit: MOVZ/MOVN, HI/LO moves and CP0
// transfers with a bounded acknowledge wait. All outputs are registered.
module move_unit
   import move_unit_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int CP0_ADDR_WIDTH = 5,
   parameter int CP0_SEL_WIDTH  = 3,
   parameter int CP0_TIMEOUT    = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INST_WIDTH-1:0]     inst,
   input  logic [DATA_WIDTH-1:0]     raw_inst,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic [DATA_WIDTH-1:0]     cond,
   input  logic                      md_we,
   input  logic [DATA_WIDTH-1:0]     md_hi,
   input  logic [DATA_WIDTH-1:0]     md_lo,
   output logic [DATA_WIDTH-1:0]     hi,
   output logic [DATA_WIDTH-1:0]     lo,
   output logic                      cp0_req,
   output logic                      cp0_we,
   output logic [CP0_ADDR_WIDTH-1:0] cp0_addr,
   output logic [CP0_SEL_WIDTH-1:0]  cp0_sel,
   output logic [DATA_WIDTH-1:0]     cp0_wdata,
   input  logic [DATA_WIDTH-1:0]     cp0_rdata,
   input  logic                      cp0_ack,
   output logic                      out_valid,
   output logic [DATA_WIDTH-1:0]     res,
   output logic                      res_we,
   output logic                      cp0_err
);

   localparam int TW = $clog2(CP0_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LIM = TW'(CP0_TIMEOUT);

   mv_state_e                 state_q;
   logic                      in_ready_q, cp0_req_q, cp0_we_q;
   logic [CP0_ADDR_WIDTH-1:0] cp0_addr_q;
   logic [CP0_SEL_WIDTH-1:0]  cp0_sel_q;
   logic [DATA_WIDTH-1:0]     cp0_wdata_q, res_q;
   logic                      out_valid_q, res_we_q, cp0_err_q;
   logic [TW-1:0]             tmo_q, tmo_d;
   logic                      accept;
   logic [DATA_WIDTH-1:0]     hi_byp, lo_byp;
   logic                      unused_raw;

   // Only the register/select fields of the raw word matter here
   assign unused_raw = ^raw_inst;

   // Flush blocks acceptance, so a flushed MTHI/MTLO never touches HI/LO
   assign accept = (state_q == MV_IDLE) && in_valid && !flush;
   assign tmo_d  = tmo_q + TW'(1);

   hilo_reg #(.W(DATA_WIDTH)) u_hilo (
      .clk       (clk),
      .rst_n     (rst_n),
      .md_we_i   (md_we),
      .md_hi_i   (md_hi),
      .md_lo_i   (md_lo),
      .mthi_we_i (accept && (inst == INST_MTHI)),
      .mtlo_we_i (accept && (inst == INST_MTLO)),
      .wdata_i   (data),
      .hi_o      (hi),
      .lo_o      (lo),
      .hi_byp_o  (hi_byp),
      .lo_byp_o  (lo_byp)
   );

   // Control FSM with registered handshake, CP0 port and result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= MV_IDLE;
         in_ready_q  <= 1'b1;
         cp0_req_q   <= 1'b0;
         cp0_we_q    <= MEM_READ;
         cp0_addr_q  <= '0;
         cp0_sel_q   <= '0;
         cp0_wdata_q <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         res_we_q    <= 1'b0;
         cp0_err_q   <= 1'b0;
         tmo_q       <= '0;
      end else if (flush) begin
         state_q     <= MV_IDLE;
         in_ready_q  <= 1'b1;
         cp0_req_q   <= 1'b0;
         out_valid_q <= 1'b0;
         res_we_q    <= 1'b0;
         cp0_err_q   <= 1'b0;
         tmo_q       <= '0;
      end else begin
         case (state_q)
            MV_IDLE: begin
               out_valid_q <= 1'b0;
               res_we_q    <= 1'b0;
               cp0_err_q   <= 1'b0;
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (is_cp0(inst)) begin
                     state_q     <= MV_CP0;
                     cp0_req_q   <= 1'b1;
                     cp0_we_q    <= (inst == INST_MTC0) ? MEM_WRITE : MEM_READ;
                     cp0_addr_q  <= raw_inst[11 +: CP0_ADDR_WIDTH];
                     cp0_sel_q   <= raw_inst[0 +: CP0_SEL_WIDTH];
                     cp0_wdata_q <= data;
                     tmo_q       <= '0;
                  end else begin
                     state_q     <= MV_RESP;
                     out_valid_q <= 1'b1;
                     case (inst)
                        INST_MOVZ: begin res_q <= data;   res_we_q <= (cond == '0); end
                        INST_MOVN: begin res_q <= data;   res_we_q <= (cond != '0); end
                        INST_MFHI: begin res_q <= hi_byp; res_we_q <= 1'b1;         end
                        INST_MFLO: begin res_q <= lo_byp; res_we_q <= 1'b1;         end
                        default:   res_we_q <= 1'b0;
                     endcase
                  end
               end
            end
            MV_CP0: begin
               // An ack in the limit cycle still completes normally
               if (cp0_ack) begin
                  state_q     <= MV_RESP;
                  cp0_req_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  res_we_q    <= (cp0_we_q == MEM_READ);
                  if (cp0_we_q == MEM_READ) res_q <= cp0_rdata;
               end else if (tmo_d == TMO_LIM) begin
                  state_q     <= MV_RESP;
                  cp0_req_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  cp0_err_q   <= 1'b1;
                  res_q       <= '0;
                  res_we_q    <= 1'b0;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            MV_RESP: begin
               state_q     <= MV_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               res_we_q    <= 1'b0;
               cp0_err_q   <= 1'b0;
            end
            default: state_q <= MV_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign cp0_req   = cp0_req_q;
   assign cp0_we    = cp0_we_q;
   assign cp0_addr  = cp0_addr_q;
   assign cp0_sel   = cp0_sel_q;
   assign cp0_wdata = cp0_wdata_q;
   assign out_valid = out_valid_q;
   assign res       = res_q;
   assign res_we    = res_we_q;
   assign cp0_err   = cp0_err_q;

endmodule

// File: tb/tb_move_unit.sv
// Directed bench for move_unit with a transaction-level reference model
// (HI/LO values and a queue of expected responses).
module tb_move_unit;
   import move_unit_pkg::*;

   localparam int DW  = 32;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    inst = '0;
   logic [DW-1:0] raw_inst = '0, data = '0, cond = '0;
   logic          md_we = 1'b0;
   logic [DW-1:0] md_hi = '0, md_lo = '0;
   logic [DW-1:0] hi, lo;
   logic          cp0_req, cp0_we;
   logic [4:0]    cp0_addr;
   logic [2:0]    cp0_sel;
   logic [DW-1:0] cp0_wdata;
   logic [DW-1:0] cp0_rdata = '0;
   logic          cp0_ack = 1'b0;
   logic          out_valid, res_we, cp0_err;
   logic [DW-1:0] res;

   move_unit #(.DATA_WIDTH(DW), .CP0_ADDR_WIDTH(5), .CP0_SEL_WIDTH(3), .CP0_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .raw_inst(raw_inst), .data(data), .cond(cond),
      .md_we(md_we), .md_hi(md_hi), .md_lo(md_lo), .hi(hi), .lo(lo),
      .cp0_req(cp0_req), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_sel(cp0_sel),
      .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .cp0_ack(cp0_ack),
      .out_valid(out_valid), .res(res), .res_we(res_we), .cp0_err(cp0_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] res;
      logic        we;
      logic        err;
      logic        chk_res;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] mhi = '0, mlo = '0;
   bit          chk_en = 0;

   // Every cycle: HI/LO against the model, each result strobe against the queue
   always @(negedge clk) begin
      if (chk_en) begin
         chk("hi", hi, mhi);
         chk("lo", lo, mlo);
         if (out_valid) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out_valid: got res=0x%08h required no strobe", res);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("res_we", {31'b0, res_we}, {31'b0, e.we});
               chk("cp0_err", {31'b0, cp0_err}, {31'b0, e.err});
               if (e.chk_res) chk("res", res, e.res);
            end
         end else begin
            chk("cp0_err_without_valid", {31'b0, cp0_err}, 32'h0);
         end
      end
   end

   // Non-CP0 instruction; called just after a rising edge with the unit idle
   task automatic op(input logic [7:0] i, input logic [31:0] d, input logic [31:0] c,
                     input bit md, input logic [31:0] mh, input logic [31:0] ml);
      logic [31:0] bh, bl;
      exp_t e;
      chk("in_ready_before_op", {31'b0, in_ready}, 32'h1);
      inst = i; data = d; cond = c; in_valid = 1'b1;
      md_we = md; md_hi = mh; md_lo = ml;
      bh = md ? mh : mhi;
      bl = md ? ml : mlo;
      e.res = d; e.we = 1'b0; e.err = 1'b0; e.chk_res = 1'b0;
      case (i)
         INST_MOVZ: begin e.we = (c == 0); e.chk_res = 1'b1; end
         INST_MOVN: begin e.we = (c != 0); e.chk_res = 1'b1; end
         INST_MFHI: begin e.res = bh; e.we = 1'b1; e.chk_res = 1'b1; end
         INST_MFLO: begin e.res = bl; e.we = 1'b1; e.chk_res = 1'b1; end
         default: ;
      endcase
      expq.push_back(e);
      @(posedge clk);
      mhi = (i == INST_MTHI) ? d : bh;
      mlo = (i == INST_MTLO) ? d : bl;
      #1;
      in_valid = 1'b0; md_we = 1'b0;
      chk("resp_latency", {31'b0, out_valid}, 32'h1);
      @(posedge clk); #1;
   endtask

   // CP0 transfer; ack_at = cycle of the request in which ack is given (0 = never)
   task automatic cp0_op(input bit wr, input logic [4:0] a, input logic [2:0] s,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
      int reqc;
      bit done;
      exp_t e;
      reqc = 0; done = 0;
      chk("in_ready_before_cp0", {31'b0, in_ready}, 32'h1);
      raw_inst = {16'h0, a, 8'h5A, s};
      inst = wr ? INST_MTC0 : INST_MFC0;
      data = wd; in_valid = 1'b1;
      if (ack_at > 0 && ack_at <= TMO) begin
         e.res = rd; e.we = !wr; e.err = 1'b0; e.chk_res = !wr;
      end else begin
         e.res = 32'h0; e.we = 1'b0; e.err = 1'b1; e.chk_res = 1'b1;
      end
      expq.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0; data = 32'hFFFF_FFFF; raw_inst = '0;
      for (int k = 1; k <= 40 && !done; k++) begin
         if (out_valid) begin
            done = 1;
         end else begin
            if (cp0_req) reqc++;
            chk("cp0_addr", {27'b0, cp0_addr}, {27'b0, a});
            chk("cp0_sel", {29'b0, cp0_sel}, {29'b0, s});
            chk("cp0_we", {31'b0, cp0_we}, {31'b0, wr});
            if (wr) chk("cp0_wdata", cp0_wdata, wd);
            if (k == ack_at) begin cp0_ack = 1'b1; cp0_rdata = rd; end
            @(posedge clk); #1;
            cp0_ack = 1'b0; cp0_rdata = 32'hDEAD_BEEF;
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL cp0_resp_bound: got no out_valid in 40 cycles required a response");
      end
      chk("cp0_req_cycles", reqc, (ack_at > 0 && ack_at <= TMO) ? ack_at : TMO);
      chk("cp0_req_dropped", {31'b0, cp0_req}, 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_cp0_req", {31'b0, cp0_req}, 32'h0);
      chk("rst_res", res, 32'h0);
      chk("rst_hi", hi, 32'h0);
      rst_n = 1'b1;
      chk_en = 1;
      @(posedge clk); #1;

      // Conditional moves
      op(INST_MOVZ, 32'h1234, 32'h0, 0, 0, 0);
      chk("movz_res_lit", res, 32'h1234);
      op(INST_MOVZ, 32'h1234, 32'h5, 0, 0, 0);
      op(INST_MOVN, 32'h5678, 32'h5, 0, 0, 0);
      op(INST_MOVN, 32'h9ABC, 32'h0, 0, 0, 0);

      // MTHI racing an md write, then read back
      op(INST_MTHI, 32'hAAAA_0000, 32'h0, 1, 32'h1, 32'h2);
      chk("mthi_hi_lit", hi, 32'hAAAA_0000);
      chk("mthi_lo_lit", lo, 32'h2);
      op(INST_MFLO, 32'h0, 32'h0, 0, 0, 0);
      chk("mflo_res_lit", res, 32'h2);
      op(INST_MFHI, 32'h0, 32'h0, 1, 32'h55, 32'h66);
      chk("mfhi_bypass_lit", res, 32'h55);
      op(INST_MTLO, 32'h0BAD_F00D, 32'h0, 0, 0, 0);
      op(INST_MFLO, 32'h0, 32'h0, 0, 0, 0);
      op(8'hFF, 32'h1111, 32'h0, 0, 0, 0);

      // CP0 read, timeout, ack exactly at the limit
      cp0_op(0, 5'd12, 3'd0, 32'h0, 3, 32'h0040_FF01);
      chk("mfc0_res_lit", res, 32'h0040_FF01);
      cp0_op(1, 5'd9, 3'd2, 32'hC0DE_0001, 0, 32'h0);
      chk("timeout_res_lit", res, 32'h0);
      cp0_op(1, 5'd11, 3'd1, 32'hC0DE_0002, TMO, 32'h0);
      cp0_op(0, 5'd15, 3'd7, 32'h0, 1, 32'h7777_0001);

      // Stray ack while idle must not produce a result
      cp0_ack = 1'b1;
      @(posedge clk); #1;
      cp0_ack = 1'b0;
      chk("stray_ack_ignored", {31'b0, out_valid}, 32'h0);

      // Flush during MTC0 wait
      raw_inst = {16'h0, 5'd3, 11'h0}; inst = INST_MTC0; data = 32'h1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_flush_req", {31'b0, cp0_req}, 32'h1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_req", {31'b0, cp0_req}, 32'h0);
      chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
      chk("flush_out_valid", {31'b0, out_valid}, 32'h0);

      // MFHI presented together with flush is not accepted
      inst = INST_MFHI; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_mfhi_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      chk("flush_mfhi_no_valid", {31'b0, out_valid}, 32'h0);

      // Reset in the middle of a CP0 wait with non-zero HI/LO
      op(INST_MTHI, 32'h1357_9BDF, 32'h0, 0, 0, 0);
      raw_inst = {16'h0, 5'd12, 11'h0}; inst = INST_MFC0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("prereset_req", {31'b0, cp0_req}, 32'h1);
      rst_n = 1'b0;
      @(posedge clk);
      mhi = '0; mlo = '0;
      #1;
      rst_n = 1'b1;
      chk("midreset_req", {31'b0, cp0_req}, 32'h0);
      chk("midreset_in_ready", {31'b0, in_ready}, 32'h1);
      chk("midreset_hi", hi, 32'h0);
      chk("midreset_lo", lo, 32'h0);

      op(INST_MOVN, 32'h2468, 32'h1, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", expq.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
